compresser: RTL and testbench
=============================

# compresser

Streaming RV32 instruction compressor and packer: the encoding-side counterpart of the decompresser. It accepts 32-bit base instructions one at a time. Each instruction that matches a supported RVC form is rewritten as its 16-bit encoding, and the resulting halfword stream is packed into little-endian 32-bit words for an instruction-memory writer. It sits between a code-generation/patch source and the memory write port, with valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- instr_i  input  32  uncompressed instruction
- valid_i  input  1  instr_i valid
- ready_o  output  1  instr_i accepted when valid_i && ready_o
- flush_i  input  1  level; emit any pending halfword padded with C.NOP
- word_o  output  32  packed output word; first halfword in [15:0]
- valid_o  output  1  word_o valid
- ready_i  input  1  downstream accepts word_o when valid_o && ready_i
- pending_o  output  1  a halfword is held in the residue register
- compressed_count_o  output  32  count of accepted instructions emitted as 16-bit

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Compression rules. A rule applies only if every listed condition holds; anything else passes through unchanged as 32-bit.
  - Pass-through also covers all JAL and branches, because their offsets are position-dependent.
  - Pass-through also covers any input with instr_i[1:0] != 2'b11.
- Compressed encodings. "rd'" and "rs1'" mean reg-8, valid only for x8..x15.
  - ADDI rd=rs1!=0, imm!=0, imm in [-32,31] -> C.ADDI {000,imm[5],rd,imm[4:0],01}
  - ADDI rs1=x0, rd!=0, imm in [-32,31] -> C.LI {010,imm[5],rd,imm[4:0],01}
  - ADDI rd!=0, rs1!=0, imm=0, rd!=rs1 -> C.MV {1000,rd,rs1,10}
  - ADD rd=rs1!=0, rs2!=0 -> C.ADD {1001,rd,rs2,10}
  - ADD rd!=0, rs1=x0, rs2!=0 -> C.MV {1000,rd,rs2,10}
  - SLLI rd=rs1!=0, shamt!=0 -> C.SLLI {0000,rd,shamt,10}
  - SUB/XOR/OR/AND with rd=rs1 and rs2 both in x8..x15 -> {100011,rd',f2,rs2',01}; f2 = 00/01/10/11 respectively
  - LW and SW: rd/rs2 and rs1 in x8..x15, offset in 0..124, offset[1:0]=0
    - C.LW {010,off[5:3],rs1',off[2],off[6],rd',00}
    - C.SW {110,off[5:3],rs1',off[2],off[6],rs2',00}
  - JALR imm=0, rs1!=0: rd=x0 -> C.JR {1000,rs1,00000,10}; rd=x1 -> C.JALR {1001,rs1,00000,10}
  - EBREAK (0x00100073) -> 0x9002
- State: residue register res_q[15:0] plus pending flag. Two states, EMPTY and HALF, encoded as pending_o.
- ready_o = !valid_o || ready_i (combinational). An output slot is free when ready_o=1.
- On accept:
  - 16-bit, EMPTY: res_q <= c16, go to HALF; no output.
  - 16-bit, HALF: word_o <= {c16,res_q}, valid_o <= 1, go to EMPTY.
  - 32-bit, EMPTY: word_o <= instr_i, valid_o <= 1, stay EMPTY.
  - 32-bit, HALF: word_o <= {instr_i[15:0],res_q}, valid_o <= 1, res_q <= instr_i[31:16], stay HALF.
- Flush: acts only in a cycle with no accept (valid_i=0), HALF, and the slot free.
  - word_o <= {16'h0001,res_q}, valid_o <= 1, go to EMPTY.
  - flush_i in EMPTY is a no-op.
- If a word is consumed and none is loaded, valid_o <= 0.
- Counter: compressed_count_o increments by 1 on each accepted compressed instruction; wraps 2^32-1 -> 0.

## Timing
- Reset values: word_o=0, valid_o=0, pending_o=0, res_q=0, compressed_count_o=0.
- Latency: a completed word appears on valid_o the cycle after the accept or flush that completes it.
- Throughput: one instruction per cycle while ready_i=1.
- Handshake rules:
  - word_o and valid_o hold stable while valid_o && !ready_i.
  - Upstream must hold instr_i while valid_i && !ready_o.
- Simultaneous consume and accept in the same cycle is allowed (pipelined slot).
- Reset mid-operation discards the residue and any unconsumed word; nothing is emitted after reset.

## Test plan
- addi x10,x10,1 (0x00150513) then addi x11,x0,5 (0x00500593) -> one word 0x45950505; compressed_count_o=2; pending_o=0.
- C.ADDI 0x00150513, then lui x5,0x12345 (0x123452B7, pass-through), then flush_i -> words 0x52B70505 then 0x00011234; pending_o=0.
- lw x8,4(x9) (0x0044A403) then ebreak -> word 0x900240C0. Then lw x8,128(x9) followed by a compressible instruction -> the lw passes through as 32-bit and count is unchanged by it.
- ebreak (0x00100073) then jalr x0,0(x1) (0x00008067) -> 0x80829002.
- Backpressure: hold ready_i=0 with valid_o=1 for 5 cycles while valid_i=1 -> ready_o=0, word_o stable, no accepts; release ready_i -> stream resumes without loss or duplication.
- Reset asserted while in HALF with valid_o=1 -> next cycle all outputs 0. A following flush_i emits nothing.

Source files
------------

// File: rtl/compresser.sv
// Streaming RV32 -> RVC compressor and halfword packer.
// Accepts one 32-bit instruction per cycle, rewrites supported forms as
// 16-bit RVC, and packs the halfword stream into little-endian 32-bit words.
module compresser (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic [31:0] word_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        pending_o,
    output logic [31:0] compressed_count_o
);

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t      state_q;
    logic [15:0] res_q;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i, imm_s;
    logic        imm_small;
    logic        rd_c, rs1_c, rs2_c;

    assign opcode    = instr_i[6:0];
    assign rd        = instr_i[11:7];
    assign f3        = instr_i[14:12];
    assign rs1       = instr_i[19:15];
    assign rs2       = instr_i[24:20];
    assign f7        = instr_i[31:25];
    assign imm_i     = instr_i[31:20];
    assign imm_s     = {instr_i[31:25], instr_i[11:7]};
    // 6-bit signed immediate: bits [11:5] must all equal the sign bit
    assign imm_small = (imm_i[11:5] == {7{imm_i[5]}});
    // Registers reachable by the 3-bit compressed register fields (x8..x15)
    assign rd_c      = (rd[4:3]  == 2'b01);
    assign rs1_c     = (rs1[4:3] == 2'b01);
    assign rs2_c     = (rs2[4:3] == 2'b01);

    logic        is_c;
    logic [15:0] c16;

    // Compression decode: is_c flags a supported form, c16 holds its encoding
    always_comb begin
        is_c = 1'b0;
        c16  = 16'h0000;
        if (instr_i == 32'h0010_0073) begin
            is_c = 1'b1;
            c16  = 16'h9002;
        end else if (instr_i[1:0] == 2'b11) begin
            case (opcode)
                7'b0010011: begin
                    if (f3 == 3'b000) begin
                        if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm_small) begin
                            is_c = 1'b1;
                            c16  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                        end else if (rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
                            is_c = 1'b1;
                            c16  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                        end else if (rd != 5'd0 && rs1 != 5'd0 && imm_i == 12'd0 && rd != rs1) begin
                            is_c = 1'b1;
                            c16  = {4'b1000, rd, rs1, 2'b10};
                        end
                    end else if (f3 == 3'b001 && f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                        is_c = 1'b1;
                        c16  = {4'b0000, rd, rs2, 2'b10};
                    end
                end
                7'b0110011: begin
                    if (f3 == 3'b000 && f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                        is_c = 1'b1;
                        c16  = {4'b1001, rd, rs2, 2'b10};
                    end else if (f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
                        is_c = 1'b1;
                        c16  = {4'b1000, rd, rs2, 2'b10};
                    end else if (rd == rs1 && rd_c && rs2_c) begin
                        if (f7 == 7'b0100000 && f3 == 3'b000) begin
                            is_c = 1'b1;
                            c16  = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                        end else if (f7 == 7'd0 && f3 == 3'b100) begin
                            is_c = 1'b1;
                            c16  = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                        end else if (f7 == 7'd0 && f3 == 3'b110) begin
                            is_c = 1'b1;
                            c16  = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                        end else if (f7 == 7'd0 && f3 == 3'b111) begin
                            is_c = 1'b1;
                            c16  = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                        end
                    end
                end
                7'b0000011: begin
                    if (f3 == 3'b010 && rd_c && rs1_c && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
                        is_c = 1'b1;
                        c16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                    end
                end
                7'b0100011: begin
                    if (f3 == 3'b010 && rs2_c && rs1_c && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
                        is_c = 1'b1;
                        c16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                    end
                end
                7'b1100111: begin
                    if (f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0) begin
                        if (rd == 5'd0) begin
                            is_c = 1'b1;
                            c16  = {4'b1000, rs1, 5'd0, 2'b10};
                        end else if (rd == 5'd1) begin
                            is_c = 1'b1;
                            c16  = {4'b1001, rs1, 5'd0, 2'b10};
                        end
                    end
                end
                default: begin
                    is_c = 1'b0;
                    c16  = 16'h0000;
                end
            endcase
        end
    end

    logic accept, flush_fire;

    // Output slot is free when empty or being drained this cycle
    assign ready_o    = !valid_o || ready_i;
    assign accept     = valid_i && ready_o;
    assign flush_fire = flush_i && !valid_i && (state_q == HALF) && ready_o;
    assign pending_o  = (state_q == HALF);

    // Packer FSM: residue handling, output word load and compressed counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= EMPTY;
            res_q              <= 16'h0000;
            word_o             <= 32'h0;
            valid_o            <= 1'b0;
            compressed_count_o <= 32'h0;
        end else begin
            if (ready_o)
                valid_o <= 1'b0;
            if (accept) begin
                if (is_c) begin
                    compressed_count_o <= compressed_count_o + 32'd1;
                    if (state_q == EMPTY) begin
                        res_q   <= c16;
                        state_q <= HALF;
                    end else begin
                        word_o  <= {c16, res_q};
                        valid_o <= 1'b1;
                        state_q <= EMPTY;
                    end
                end else begin
                    valid_o <= 1'b1;
                    if (state_q == EMPTY) begin
                        word_o <= instr_i;
                    end else begin
                        word_o <= {instr_i[15:0], res_q};
                        res_q  <= instr_i[31:16];
                    end
                end
            end else if (flush_fire) begin
                // Pad the lone halfword with C.NOP
                word_o  <= {16'h0001, res_q};
                valid_o <= 1'b1;
                state_q <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_compresser.sv
// Testbench for compresser: table-driven instruction vectors feeding a
// halfword scoreboard, plus hand-written packing, backpressure and reset cases.
module tb_compresser;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [31:0] word_o;
    logic        valid_o;
    logic        ready_i;
    logic        pending_o;
    logic [31:0] compressed_count_o;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] hw_q[$];
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic [31:0] instr;
        bit          is_c;
        logic [15:0] c16;
    } vec_t;

    vec_t vecs[$];

    compresser dut (
        .clk                (clk),
        .reset              (reset),
        .instr_i            (instr_i),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .flush_i            (flush_i),
        .word_o             (word_o),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .pending_o          (pending_o),
        .compressed_count_o (compressed_count_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] ins, input bit c, input logic [15:0] h);
        vec_t v;
        v.instr = ins;
        v.is_c  = c;
        v.c16   = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, then observe consume/accept before the next posedge
    task automatic cycle(input bit v, input logic [31:0] ins, input bit fl, input bit rdy,
                         input bit is_c, input logic [15:0] c16, output bit acc);
        logic [31:0] exp;
        @(negedge clk);
        valid_i = v;
        instr_i = ins;
        flush_i = fl;
        ready_i = rdy;
        #1;
        acc = v && ready_o;
        if (valid_o && ready_i) begin
            if (hw_q.size() < 2) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h, expected no word", word_o);
            end else begin
                exp = {hw_q[1], hw_q[0]};
                void'(hw_q.pop_front());
                void'(hw_q.pop_front());
                chk("word", word_o, exp);
            end
        end
        if (acc) begin
            if (is_c) begin
                hw_q.push_back(c16);
                exp_count = exp_count + 32'd1;
            end else begin
                hw_q.push_back(ins[15:0]);
                hw_q.push_back(ins[31:16]);
            end
        end else if (fl && !v && ready_o && (hw_q.size() % 2 == 1)) begin
            hw_q.push_back(16'h0001);
        end
    endtask

    // rmode: 0 = ready_i high, 1 = random ready_i, 2 = ready_i low
    task automatic send(input logic [31:0] ins, input bit is_c, input logic [15:0] c16, input int rmode);
        bit acc;
        bit r;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            r = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(1'b1, ins, 1'b0, r, is_c, c16, acc);
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: instr %h not accepted, expected accept within 50 cycles", ins);
        end
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (n < 20 && (hw_q.size() >= 2 || valid_o)) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0, acc);
            n++;
        end
        chk("drain_words_left", hw_q.size() / 2, 32'd0);
        chk("pending", {31'd0, pending_o}, hw_q.size() % 2);
        chk("count", compressed_count_o, exp_count);
    endtask

    task automatic flush_drain();
        bit acc;
        drain();
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0, acc);
        drain();
        chk("pending_after_flush", {31'd0, pending_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        instr_i = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_word", word_o, 32'h0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pending", {31'd0, pending_o}, 32'd0);
        chk("rst_count", compressed_count_o, 32'd0);
        reset = 1'b0;
        hw_q.delete();
        exp_count = 32'd0;
    endtask

    initial begin
        bit acc;
        reset   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        instr_i = 32'h0;

        vecs.push_back(mk(32'h0015_0513, 1'b1, 16'h0505)); // addi x10,x10,1
        vecs.push_back(mk(32'h0050_0593, 1'b1, 16'h4595)); // li x11,5
        vecs.push_back(mk(32'h0005_8513, 1'b1, 16'h852E)); // mv x10,x11 (addi)
        vecs.push_back(mk(32'h00B5_0533, 1'b1, 16'h952E)); // add x10,x10,x11
        vecs.push_back(mk(32'h00B0_0533, 1'b1, 16'h852E)); // add x10,x0,x11
        vecs.push_back(mk(32'h0035_1513, 1'b1, 16'h050E)); // slli x10,x10,3
        vecs.push_back(mk(32'h4094_0433, 1'b1, 16'h8C05)); // sub x8,x8,x9
        vecs.push_back(mk(32'h0094_7433, 1'b1, 16'h8C65)); // and x8,x8,x9
        vecs.push_back(mk(32'h00F4_C4B3, 1'b1, 16'h8CBD)); // xor x9,x9,x15
        vecs.push_back(mk(32'h0094_2423, 1'b1, 16'hC404)); // sw x9,8(x8)
        vecs.push_back(mk(32'h06F4_2E23, 1'b1, 16'hDC7C)); // sw x15,124(x8)
        vecs.push_back(mk(32'h0044_A403, 1'b1, 16'h40C0)); // lw x8,4(x9)
        vecs.push_back(mk(32'h0010_0073, 1'b1, 16'h9002)); // ebreak
        vecs.push_back(mk(32'h0002_80E7, 1'b1, 16'h9282)); // jalr x1,0(x5)
        vecs.push_back(mk(32'hFE00_0513, 1'b1, 16'h5501)); // li x10,-32
        vecs.push_back(mk(32'h0804_A403, 1'b0, 16'h0000)); // lw x8,128(x9)
        vecs.push_back(mk(32'h1234_52B7, 1'b0, 16'h0000)); // lui
        vecs.push_back(mk(32'h0080_00EF, 1'b0, 16'h0000)); // jal
        vecs.push_back(mk(32'h00B5_0463, 1'b0, 16'h0000)); // beq
        vecs.push_back(mk(32'h0205_0513, 1'b0, 16'h0000)); // addi x10,x10,32
        vecs.push_back(mk(32'h0098_7833, 1'b0, 16'h0000)); // and x16,x16,x9
        vecs.push_back(mk(32'h0015_0510, 1'b0, 16'h0000)); // low bits != 11
        vecs.push_back(mk(32'h0005_0513, 1'b0, 16'h0000)); // addi x10,x10,0
        vecs.push_back(mk(32'h0040_8067, 1'b0, 16'h0000)); // jalr x0,4(x1)
        vecs.push_back(mk(32'h0000_0013, 1'b0, 16'h0000)); // nop

        do_reset();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        // Two compressed halves form one word
        send(32'h0015_0513, 1'b1, 16'h0505, 0);
        send(32'h0050_0593, 1'b1, 16'h4595, 0);
        drain();
        chk("seqA_count", compressed_count_o, 32'd2);

        // Compressed + 32-bit straddle, then flush pads the residue
        send(32'h0015_0513, 1'b1, 16'h0505, 0);
        send(32'h1234_52B7, 1'b0, 16'h0000, 0);
        flush_drain();

        // lw/ebreak pair, then out-of-range lw passes through
        send(32'h0044_A403, 1'b1, 16'h40C0, 0);
        send(32'h0010_0073, 1'b1, 16'h9002, 0);
        drain();
        send(32'h0804_A403, 1'b0, 16'h0000, 0);
        send(32'h0015_0513, 1'b1, 16'h0505, 0);
        flush_drain();

        // ebreak then jr
        send(32'h0010_0073, 1'b1, 16'h9002, 0);
        send(32'h0000_8067, 1'b1, 16'h8082, 0);
        drain();

        // Backpressure: output held while ready_i is low
        send(32'h1234_52B7, 1'b0, 16'h0000, 2);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h00B5_0533, 1'b0, 1'b0, 1'b1, 16'h952E, acc);
            chk("bp_ready", {31'd0, ready_o}, 32'd0);
            chk("bp_word", word_o, 32'h1234_52B7);
        end
        send(32'h00B5_0533, 1'b1, 16'h952E, 0);
        flush_drain();

        // Table pass at full rate, then with random backpressure
        foreach (vecs[i]) send(vecs[i].instr, vecs[i].is_c, vecs[i].c16, 0);
        flush_drain();
        foreach (vecs[i]) send(vecs[i].instr, vecs[i].is_c, vecs[i].c16, 1);
        flush_drain();

        // Reset while HALF with a word waiting
        send(32'h0015_0513, 1'b1, 16'h0505, 0);
        send(32'h1234_52B7, 1'b0, 16'h0000, 2);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, acc);
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_rst_pending", {31'd0, pending_o}, 32'd1);
        do_reset();
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0, acc);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0, acc);
        chk("post_rst_flush_valid", {31'd0, valid_o}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
